// File: rtl/fifo_param_thr.sv
// Synchronous FIFO with runtime-programmable almost-full/almost-empty thresholds
// and sticky overflow/underflow error flags.
module fifo_param_thr #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   af_thr,
  input  logic [ADDR_WIDTH:0]   ae_thr,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  logic is_empty_c;
  logic is_full_c;
  logic pop_ok_c;
  logic push_ok_c;
  logic ovf_set_c;
  logic unf_set_c;

  // Acceptance: a pop frees a slot, so a full FIFO can take a push in the same cycle.
  always_comb begin
    is_empty_c = (fifo_count == CW'(0));
    is_full_c  = (fifo_count == CW'(DEPTH));
    pop_ok_c   = rd_en && !is_empty_c;
    push_ok_c  = wr_en && (!is_full_c || pop_ok_c);
    ovf_set_c  = wr_en && is_full_c && !rd_en;
    unf_set_c  = rd_en && is_empty_c;
  end

  // Status flags follow the current occupancy and thresholds.
  always_comb begin
    empty        = is_empty_c;
    full         = is_full_c;
    almost_full  = (fifo_count >= af_thr);
    almost_empty = (fifo_count <= ae_thr);
  end

  // Storage array is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && push_ok_c) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
    end else begin
      valid_out <= pop_ok_c;
      if (push_ok_c) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (pop_ok_c) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
      end
      if (push_ok_c && !pop_ok_c) begin
        fifo_count <= fifo_count + CW'(1);
      end else if (pop_ok_c && !push_ok_c) begin
        fifo_count <= fifo_count - CW'(1);
      end
    end
  end

  // Sticky errors: a new error in the clear cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set_c) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (unf_set_c) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_param_thr.sv
// Scoreboard bench for fifo_param_thr with DEPTH=4: directed stimulus, popped words
// checked by an independent monitor against an expected-data queue.
module tb_fifo_param_thr;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] data_in;
  logic [AW:0]   af_thr;
  logic [AW:0]   ae_thr;
  logic          err_clr;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [AW:0]   fifo_count;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];

  fifo_param_thr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .af_thr(af_thr), .ae_thr(ae_thr), .err_clr(err_clr),
    .data_out(data_out), .valid_out(valid_out), .fifo_count(fifo_count),
    .empty(empty), .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented word must be the next expected one.
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pop: got 0x%0h expected no valid_out", data_out);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          failures++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h", data_out, e);
        end
      end
    end
  end

  // One clock of stimulus; the reference queue predicts what gets popped.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d,
                      input logic c = 1'b0);
    bit pop_ok;
    bit push_ok;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    err_clr = c;
    pop_ok  = r && (model_q.size() != 0);
    push_ok = w && ((model_q.size() != DEPTH) || pop_ok);
    if (pop_ok)  exp_q.push_back(model_q.pop_front());
    if (push_ok) model_q.push_back(d);
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic do_reset(input logic w, input logic r);
    rst   = 1'b1;
    wr_en = w;
    rd_en = r;
    data_in = 8'hEE;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    model_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    data_in = '0; af_thr = 3'd3; ae_thr = 3'd1;
    @(posedge clk);
    #1;
    do_reset(1'b0, 1'b0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_valid", 32'(valid_out), 0);
    check("rst_dout", 32'(data_out), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_unf", 32'(underflow), 0);
    check("c0_ae", 32'(almost_empty), 1);
    check("c0_af", 32'(almost_full), 0);

    // Fill with threshold checks at each occupancy (af_thr=3, ae_thr=1)
    step(1, 0, 8'h11);
    check("c1_count", 32'(fifo_count), 1);
    check("c1_ae", 32'(almost_empty), 1);
    check("c1_af", 32'(almost_full), 0);
    step(1, 0, 8'h22);
    check("c2_ae", 32'(almost_empty), 0);
    check("c2_af", 32'(almost_full), 0);
    step(1, 0, 8'h33);
    check("c3_af", 32'(almost_full), 1);
    check("c3_full", 32'(full), 0);
    step(1, 0, 8'h44);
    check("c4_count", 32'(fifo_count), 4);
    check("c4_full", 32'(full), 1);
    check("c4_af", 32'(almost_full), 1);

    // Threshold edge values while full
    af_thr = 3'd5; #1;
    check("af_above_depth", 32'(almost_full), 0);
    ae_thr = 3'd4; #1;
    check("ae_at_depth", 32'(almost_empty), 1);
    af_thr = 3'd3; ae_thr = 3'd1; #1;

    for (int i = 0; i < 4; i++) step(0, 1, 8'h00);
    check("drain_empty", 32'(empty), 1);
    check("drain_count", 32'(fifo_count), 0);
    af_thr = 3'd0; #1;
    check("af_zero_empty", 32'(almost_full), 1);
    af_thr = 3'd3; #1;

    // Overflow while full, then clear
    step(1, 0, 8'hA1); step(1, 0, 8'hA2); step(1, 0, 8'hA3); step(1, 0, 8'hA4);
    step(1, 0, 8'h55);
    check("ovf_count", 32'(fifo_count), 4);
    check("ovf_set", 32'(overflow), 1);
    step(0, 0, 8'h00);
    check("ovf_hold", 32'(overflow), 1);
    step(0, 0, 8'h00, 1'b1);
    check("ovf_clr", 32'(overflow), 0);

    // Full with simultaneous push and pop
    step(1, 1, 8'h66);
    check("rw_full_count", 32'(fifo_count), 4);
    check("rw_full_ovf", 32'(overflow), 0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'h00);
    check("rw_drain_empty", 32'(empty), 1);

    // Underflow: no valid, data_out keeps last popped word
    step(0, 1, 8'h00);
    check("unf_set", 32'(underflow), 1);
    check("unf_valid", 32'(valid_out), 0);
    check("unf_dout", 32'(data_out), 32'h66);
    step(0, 0, 8'h00, 1'b1);
    check("unf_clr", 32'(underflow), 0);

    // Set coinciding with clear keeps the flag
    step(0, 1, 8'h00, 1'b1);
    check("unf_set_wins", 32'(underflow), 1);
    step(0, 0, 8'h00, 1'b1);

    // Empty with push and pop together
    step(1, 1, 8'h77);
    check("empty_rw_count", 32'(fifo_count), 1);
    check("empty_rw_unf", 32'(underflow), 1);
    step(0, 1, 8'h00, 1'b1);
    check("empty_rw_clr", 32'(underflow), 0);

    // Interleaved traffic across pointer wrap
    step(1, 0, 8'h80); step(1, 0, 8'h81);
    for (int i = 2; i < 10; i++) step(1, 1, 8'(8'h80 + i));
    check("wrap_count", 32'(fifo_count), 2);
    step(0, 1, 8'h00); step(0, 1, 8'h00);
    check("wrap_empty", 32'(empty), 1);

    // Reset mid-operation with count 3 and errors pending
    step(1, 0, 8'hB1); step(1, 0, 8'hB2); step(1, 0, 8'hB3); step(1, 0, 8'hB4);
    step(1, 0, 8'hC0);
    step(0, 1, 8'h00);
    check("pre_rst_count", 32'(fifo_count), 3);
    check("pre_rst_ovf", 32'(overflow), 1);
    do_reset(1'b1, 1'b1);
    check("mid_rst_count", 32'(fifo_count), 0);
    check("mid_rst_empty", 32'(empty), 1);
    check("mid_rst_valid", 32'(valid_out), 0);
    check("mid_rst_ovf", 32'(overflow), 0);
    check("mid_rst_unf", 32'(underflow), 0);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_param_thr.md
FIFO_PARAM_THR -- requirements
Module: fifo_param_thr

Interface
REQ-001 Parameter DATA_WIDTH, default 8: word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 3: pointer width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; the ports are listed below.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 wr_en  in  1  push request.
REQ-007 rd_en  in  1  pop request.
REQ-008 data_in  in  DATA_WIDTH  word to push.
REQ-009 af_thr  in  ADDR_WIDTH+1  almost-full threshold, runtime programmable.
REQ-010 ae_thr  in  ADDR_WIDTH+1  almost-empty threshold, runtime programmable.
REQ-011 err_clr  in  1  clears sticky error flags.
REQ-012 data_out  out  DATA_WIDTH  registered popped word.
REQ-013 valid_out  out  1  data_out was loaded at the previous edge.
REQ-014 fifo_count  out  ADDR_WIDTH+1  words stored, 0..DEPTH.
REQ-015 empty, full, almost_full, almost_empty  out  1 each  status flags.
REQ-016 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-017 The block SHALL accept a pop when rd_en=1 and fifo_count!=0.
REQ-018 The block SHALL accept a push when wr_en=1 and (fifo_count!=DEPTH or a pop is accepted in the same cycle).
- Full plus simultaneous read/write: both accepted; fifo_count stays DEPTH.
REQ-019 An accepted push SHALL write data_in to mem[wr_ptr] and increment wr_ptr modulo DEPTH; a rejected push SHALL leave memory and wr_ptr unchanged.
REQ-020 An accepted pop SHALL load data_out with mem[rd_ptr], set valid_out=1 for the next cycle and increment rd_ptr modulo DEPTH.
- No accepted pop: data_out holds its value; valid_out=0.
- Latency: one cycle from rd_en sample to data_out/valid_out.
REQ-021 fifo_count SHALL update as follows:
- +1 on push only.
- -1 on pop only.
- Unchanged on both or neither.
REQ-022 Empty with both wr_en and rd_en: push accepted, pop rejected, underflow set, fifo_count becomes 1.
REQ-023 Flags SHALL be combinational from fifo_count and the thresholds:
- empty = (count==0).
- full = (count==DEPTH).
- almost_full = (count >= af_thr).
- almost_empty = (count <= ae_thr).
REQ-024 Threshold edge values:
- af_thr=0: almost_full always 1.
- af_thr>DEPTH: almost_full never asserts.
- ae_thr>=DEPTH: almost_empty always 1.
REQ-025 overflow SHALL set on wr_en=1 with count==DEPTH and rd_en=0; underflow SHALL set on rd_en=1 with count==0.
REQ-026 Both error flags SHALL hold until err_clr=1 or rst=1; a set condition coinciding with err_clr SHALL win (flag remains 1).
REQ-027 Pointer wrap SHALL be silent; stored data order SHALL be strict FIFO across wrap-around.

Reset
REQ-028 On rst=1 at a rising edge, the block SHALL clear fifo_count, wr_ptr, rd_ptr, data_out, valid_out, overflow and underflow to 0; memory contents are not cleared.
REQ-029 rst SHALL take priority over wr_en, rd_en and err_clr in the same cycle; reset mid-operation discards all stored words (empty=1 next cycle).

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4)
REQ-030 Push 0x11,0x22,0x33,0x44, then pop four -> data_out 0x11,0x22,0x33,0x44 each one cycle after rd_en with valid_out=1; full=1 after the 4th push; empty=1 at the end.
REQ-031 Full, then wr_en=1 with data 0x55 and rd_en=0 -> count stays 4, overflow=1 and holds until err_clr; later pops return no 0x55.
REQ-032 Full, then wr_en=rd_en=1 with 0x66 -> data_out=0x11, count stays 4, overflow=0; 0x66 emerges after 0x44.
REQ-033 Empty, then rd_en=1 -> underflow=1, valid_out=0, data_out unchanged; err_clr=1 with no new error -> underflow=0 next cycle.
REQ-034 af_thr=3, ae_thr=1, pushes 0 to 4 -> almost_empty=1 at count 0-1, almost_full=1 at count 3-4; 10 pushes/pops interleaved across wrap keep order.
REQ-035 rst=1 with count=3 and wr_en=1 -> next cycle count=0, empty=1, valid_out=0, error flags=0.
